symbol_draw_arbiter: RTL
========================

Name: symbol_draw_arbiter

Overview:
- Shares one VGA plot port (x 8-bit, y 7-bit, colour 3-bit, plot strobe) among 4 requesters.
- Each requester asks for one symbol to be drawn into a 16x16 board cell.
- The block arbitrates round-robin, latches the winner's request and sequences every pixel of the symbol onto the plot port, one pixel per clock.
- Sits between the game-logic FSMs and the VGA adapter.

Parameters:
- NREQ, 4, number of requesters (design and test at 4 only).
- CELL, 16, cell edge in pixels (fixed; offsets are 4-bit).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- req  input  4  per-requester level request; hold until matching gnt
- req_x  input  32  base x per requester, requester i at bits [8i+7:8i]
- req_y  input  28  base y per requester, requester i at bits [7i+6:7i]
- req_sym  input  8  symbol per requester, requester i at bits [2i+1:2i]: 00 erase, 01 X, 10 fill, 11 treated as erase
- gnt  output  4  one-cycle one-hot pulse: request accepted, inputs latched
- done  output  4  one-cycle one-hot pulse: last pixel of that requester's symbol emitted
- busy  output  1  high from grant until the done cycle inclusive
- xout  output  8  pixel x
- yout  output  7  pixel y
- colour  output  3  pixel colour
- plot  output  1  write strobe; xout/yout/colour are valid when high

Behaviour:
- Reset (async, active-low): all outputs 0; state IDLE; RR pointer 0 (requester 0 highest priority).
- Reset mid-draw aborts the draw; no done pulse is issued.
- All outputs are registered.

States: IDLE, DRAW, FIN.

IDLE:
- With any req bit set at an edge, pick winner w: first set bit scanning from pointer upward mod 4.
- At that edge: gnt[w]<=1; latch bx, by, sym of w; idx<=0; busy<=1; pointer<=(w+1) mod 4; go to DRAW.
- No req: stay in IDLE, plot 0.

DRAW (one pixel per edge):
- Each edge: plot<=1; xout<=bx+xo(idx); yout<=by+yo(idx); colour per symbol; idx<=idx+1.
- gnt is 0 throughout.
- Leave to FIN on the edge that emits the final idx.
- X: 32 pixels, colour 101.
  - idx 0..15: xo=idx, yo=idx.
  - idx 16..31: xo=31-idx, yo=idx-16.
- Fill: 256 pixels, colour 010; xo=idx[3:0], yo=idx[7:4] (row-major).
- Erase: same 256-pixel order, colour 000.

FIN (single cycle):
- At that edge: plot<=0; done[w]<=1; busy<=0 on the following edge; go to IDLE.
- A new grant can occur on the edge after FIN.

Latency and throughput:
- Request sampled at edge E: gnt high E..E+1; first pixel visible after edge E+1.
- X: last pixel after E+32; done after E+33.
- Fill/erase: done after E+257.

Arithmetic:
- x sum is truncated mod 256; y sum is truncated mod 128.
- No clipping; requesters keep bx<=144 and by<=104.

Arbitration rules:
- req inputs are ignored outside IDLE.
- A req dropped before its grant is never served.
- A req still high after its done re-enters arbitration behind the others.
- req_x, req_y and req_sym changes after gnt have no effect on the draw in progress.

Test Plan:
- Reset then req=0001, req_x[7:0]=40, req_y[6:0]=30, sym=01 -> gnt=0001 one cycle. 32 plot pixels: (40,30),(41,31)…(55,45), then (55,30),(54,31)…(40,45), colour 101. done=0001 exactly one cycle after the last pixel; busy low afterward.
- req=0001, sym=10, base (0,0) -> 256 pixels (0,0),(1,0)…(15,0),(0,1)…(15,15), colour 010. done after 257 cycles from gnt.
- req=1111 held continuously, all sym=01 -> grants in order 0001, 0010, 0100, 1000, 0001. Exactly one gnt and one done per draw; plot never overlaps between draws.
- Pointer at 2 after serving requester 1; req=0011 -> requester 0 granted before requester 1.
- Assert reset_n=0 at pixel 10 of an X draw -> all outputs 0 immediately, no done. After release, req=0100 -> requester 2 granted normally, pointer restarted at 0.
- Base (150,120), sym 01 -> first pixel (150,120); pixel idx 6 = (156,126); idx 7 = (157,127); idx 8 = (158,0) (y wraps mod 128); idx 15 = (165,7) (truncation, no clipping).

Source files
------------

// File: rtl/symbol_draw_arbiter.sv
// symbol_draw_arbiter: round-robin arbiter that shares one VGA plot port
// among NREQ requesters. The winner's base position and symbol are latched
// at grant, then every pixel of the symbol is streamed out one per clock.
//
// Handshake: a requester holds req[i] high until it sees gnt[i]; gnt is a
// one-cycle pulse meaning "inputs latched". done[i] pulses one cycle after
// the last pixel of that requester's symbol was plotted. req is only looked
// at while idle, so a request dropped before its grant is simply never served.
module symbol_draw_arbiter #(
  parameter int NREQ = 4,
  parameter int CELL = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_x,
  input  logic [7*NREQ-1:0]    req_y,
  input  logic [2*NREQ-1:0]    req_sym,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [7:0]           xout,
  output logic [6:0]           yout,
  output logic [2:0]           colour,
  output logic                 plot,
  output logic [1:0]           state_dbg
);

  localparam int PW = $clog2(NREQ);
  localparam logic [7:0] LAST_X    = 8'(2 * CELL - 1);
  localparam logic [7:0] LAST_FILL = 8'(CELL * CELL - 1);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_FIN} state_t;

  state_t          state, state_n;
  logic [PW-1:0]   ptr, ptr_n;
  logic [PW-1:0]   w, w_n;
  logic [7:0]      bx, bx_n;
  logic [6:0]      by, by_n;
  logic [1:0]      sym, sym_n;
  logic [7:0]      idx, idx_n;
  logic [NREQ-1:0] gnt_n, done_n;
  logic            busy_n, plot_n;
  logic [7:0]      xout_n;
  logic [6:0]      yout_n;
  logic [2:0]      colour_n;

  logic            win_found;
  logic [PW-1:0]   win, cand;
  logic [7:0]      sel_x;
  logic [6:0]      sel_y;
  logic [1:0]      sel_sym;
  logic [3:0]      xo, yo;
  logic            last_pix;
  logic [2:0]      sym_colour;

  assign state_dbg = state;

  // Round-robin pick: first set req bit scanning upward from ptr, plus the
  // winner's slice of the packed request buses.
  always_comb begin
    win_found = 1'b0;
    win       = ptr;
    cand      = ptr;
    sel_x     = '0;
    sel_y     = '0;
    sel_sym   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + PW'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        sel_x   = req_x[8*i +: 8];
        sel_y   = req_y[7*i +: 7];
        sel_sym = req_sym[2*i +: 2];
      end
    end
  end

  // Pixel offset within the cell for the current index; the X is drawn as
  // the main diagonal then the anti-diagonal, fill/erase as row-major scan.
  always_comb begin
    if (sym == 2'b01) begin
      xo       = idx[4] ? ~idx[3:0] : idx[3:0];
      yo       = idx[3:0];
      last_pix = (idx == LAST_X);
    end else begin
      xo       = idx[3:0];
      yo       = idx[7:4];
      last_pix = (idx == LAST_FILL);
    end
    case (sym)
      2'b01:   sym_colour = 3'b101;
      2'b10:   sym_colour = 3'b010;
      default: sym_colour = 3'b000;
    endcase
  end

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    w_n      = w;
    bx_n     = bx;
    by_n     = by;
    sym_n    = sym;
    idx_n    = idx;
    gnt_n    = '0;
    done_n   = '0;
    busy_n   = busy;
    plot_n   = 1'b0;
    xout_n   = xout;
    yout_n   = yout;
    colour_n = colour;
    case (state)
      S_IDLE: begin
        busy_n = 1'b0;
        if (win_found) begin
          gnt_n[win] = 1'b1;
          w_n        = win;
          bx_n       = sel_x;
          by_n       = sel_y;
          sym_n      = sel_sym;
          idx_n      = '0;
          busy_n     = 1'b1;
          ptr_n      = win + PW'(1);
          state_n    = S_DRAW;
        end
      end
      S_DRAW: begin
        plot_n   = 1'b1;
        xout_n   = bx + {4'b0000, xo};
        yout_n   = by + {3'b000, yo};
        colour_n = sym_colour;
        idx_n    = idx + 8'd1;
        if (last_pix) state_n = S_FIN;
      end
      S_FIN: begin
        // busy stays high through the done cycle and drops in IDLE.
        done_n[w] = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any draw without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      ptr    <= '0;
      w      <= '0;
      bx     <= '0;
      by     <= '0;
      sym    <= '0;
      idx    <= '0;
      gnt    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      plot   <= 1'b0;
      xout   <= '0;
      yout   <= '0;
      colour <= '0;
    end else begin
      state  <= state_n;
      ptr    <= ptr_n;
      w      <= w_n;
      bx     <= bx_n;
      by     <= by_n;
      sym    <= sym_n;
      idx    <= idx_n;
      gnt    <= gnt_n;
      done   <= done_n;
      busy   <= busy_n;
      plot   <= plot_n;
      xout   <= xout_n;
      yout   <= yout_n;
      colour <= colour_n;
    end
  end

endmodule
